muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, downstream of the register file.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_iter_core.sv | 53 +++++
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   XLEN, RADDR_W : operand/result width and register address width
//   F3_*          : funct3 opcodes (MUL..REMU)
//   state_t       : FSM state encoding
package muldiv_pkg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request / writeback bundle for muldiv_unit.
//   master : issues start/kill/funct3/operands/rd_addr, observes status and result
//   slave  : the unit; returns busy/done/result/rd_out/we_out
interface muldiv_if;
  import muldiv_pkg::*;

  logic               start;
  logic               kill;
  logic [2:0]         funct3;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [RADDR_W-1:0] rd_addr;
  logic               busy;
  logic               done;
  logic [XLEN-1:0]    result;
  logic [RADDR_W-1:0] rd_out;
  logic               we_out;

  modport master (
    output start, kill, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, result, rd_out, we_out
  );

  modport slave (
    input  start, kill, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, result, rd_out, we_out
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: 64-bit accumulator plus the latched
// multiplicand/divisor, advanced one shift-add or shift-subtract per step.
//   clk, rst   : clock, async active-high reset
//   load       : capture load_lo into acc[31:0] (acc[63:32] cleared) and load_opnd
//   step       : perform one iteration
//   div_mode   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc        : multiply -> {hi,lo} product; divide -> {remainder, quotient}
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   load_lo,
  input  logic [XLEN-1:0]   load_opnd,
  output logic [2*XLEN-1:0] acc
);
  logic [XLEN-1:0]   opnd;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    // Multiply: add multiplicand into the high half when the low bit is set,
    // then shift the whole 65-bit value right.
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift {rem,quot} left; the partial remainder needs 33 bits
    // because it can reach twice the divisor before the trial subtract.
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd};
    if (div_mode) begin
      if (diff[XLEN]) acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {add_sum, acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{XLEN{1'b0}}, load_lo};
      opnd <= load_opnd;
    end else if (step) begin
      acc  <= acc_nxt;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (one op in flight, 33-cycle latency,
// divide-by-zero and signed-overflow resolved in 1 iteration-free pass).
//   clk, rst : clock, async active-high reset
//   bus      : muldiv_if.slave (start/kill/funct3/rs1_val/rs2_val/rd_addr in,
//              busy/done/result/rd_out/we_out out, all outputs registered)
//
// state  | meaning
// S_IDLE | waiting for start; busy=0
// S_CALC | 32 radix-2 iterations, cnt 0..31
// S_FIN  | sign fix-up, register result, pulse done
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  state_t             state;
  logic [4:0]         cnt;
  logic [2:0]         op;
  logic [RADDR_W-1:0] rd_q;
  logic               neg_q;
  logic               neg_r;
  logic               fast_q;
  logic [XLEN-1:0]    fast_val;

  logic               sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               in_div, div_zero, div_ovf, fast_in, accept;
  logic [XLEN-1:0]    fast_res;
  logic [2*XLEN-1:0]  acc;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quot, rem, fix_res;

  assign sgn_a    = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) && (bus.funct3 != F3_REMU);
  assign sgn_b    = sgn_a && (bus.funct3 != F3_MULHSU);
  assign neg_a    = sgn_a & bus.rs1_val[XLEN-1];
  assign neg_b    = sgn_b & bus.rs2_val[XLEN-1];
  assign mag_a    = neg_a ? -bus.rs1_val : bus.rs1_val;
  assign mag_b    = neg_b ? -bus.rs2_val : bus.rs2_val;
  assign in_div   = is_div_op(bus.funct3);
  assign div_zero = in_div && (bus.rs2_val == '0);
  assign div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                    (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
  assign fast_in  = div_zero || div_ovf;
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign fast_res = div_zero ? (bus.funct3[1] ? bus.rs1_val : '1)
                             : (bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  assign accept   = (state == S_IDLE) && bus.start && !bus.kill;

  muldiv_iter_core u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && !fast_in),
    .step      ((state == S_CALC) && !bus.kill),
    .div_mode  (op[2]),
    .load_lo   (in_div ? mag_a : mag_b),
    .load_opnd (in_div ? mag_b : mag_a),
    .acc       (acc)
  );

  assign prod = neg_q ? -acc : acc;
  assign quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = prod[XLEN-1:0];
    case (op)
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quot;
      F3_REM, F3_REMU:              fix_res = rem;
      default:                      fix_res = prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op         <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      fast_q     <= 1'b0;
      fast_val   <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.we_out <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.we_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op       <= bus.funct3;
            rd_q     <= bus.rd_addr;
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            fast_q   <= fast_in;
            fast_val <= fast_res;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= fast_in ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          if (bus.kill) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_FIN;
          end
        end
        S_FIN: begin
          state    <= S_IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
          if (!bus.kill) begin
            bus.result <= fast_q ? fast_val : fix_res;
            bus.rd_out <= rd_q;
            bus.done   <= 1'b1;
            bus.we_out <= (rd_q != '0);
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, divide corner
// cases, kill/ignored-start/async-reset behaviour, then random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic fast_case(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return ((f == F3_DIV) || (f == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (f)
      F3_MUL:    begin p = sa * sb;        r = p[31:0];  end
      F3_MULH:   begin p = sa * sb;        r = p[63:32]; end
      F3_MULHSU: begin p = 64'(sa) * ub;   r = p[63:32]; end
      F3_MULHU:  begin p = ua * ub;        r = p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      F3_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Called just after a rising edge with the unit idle (or in its done cycle).
  // Latency is the number of rising edges after the accepting edge until done is seen.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit poke, input string tag);
    int          lat;
    int          exp_lat;
    logic [31:0] exp_res;
    exp_res = ref_model(f, a, b);
    exp_lat = fast_case(f, a, b) ? 1 : 33;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.funct3  = 3'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.rd_addr = 5'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke && i == 5) bus.start = 1'b1;
      if (poke && i == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    check({tag, " we_out"}, 32'(bus.we_out), 32'(rd != 5'd0));
    last_res = exp_res;
    last_rd  = rd;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    bus.start   = 1'b0;
    bus.kill    = 1'b0;
    bus.funct3  = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   32'(bus.busy),   32'd0);
    check("reset done",   32'(bus.done),   32'd0);
    check("reset we_out", 32'(bus.we_out), 32'd0);
    check("reset result", bus.result,      32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1, 1'b0, "mul_7x-3");
    check("mul_7x-3 const", bus.result, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    check("done single pulse", 32'(bus.done), 32'd0);
    check("idle busy", 32'(bus.busy), 32'd0);
    do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0, "mulh_min");
    check("mulh_min const", bus.result, 32'h4000_0000);
    do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, "mulhu_max");
    check("mulhu_max const", bus.result, 32'hFFFF_FFFE);
    do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4, 1'b0, "mulhsu");
    check("mulhsu const", bus.result, 32'hFFFF_FFFF);
    do_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5, 1'b0, "div_-7/2");
    check("div_-7/2 const", bus.result, 32'hFFFF_FFFD);
    do_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 1'b0, "rem_-7/2");
    check("rem_-7/2 const", bus.result, 32'hFFFF_FFFF);
    do_op(F3_DIVU,   32'd100,       32'd7,         5'd7, 1'b0, "divu_100/7");
    check("divu_100/7 const", bus.result, 32'd14);
    do_op(F3_DIVU,   32'd5,         32'd0,         5'd8, 1'b0, "divu_by0");
    check("divu_by0 const", bus.result, 32'hFFFF_FFFF);
    do_op(F3_REMU,   32'd5,         32'd0,         5'd9, 1'b0, "remu_by0");
    check("remu_by0 const", bus.result, 32'd5);
    do_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, "div_ovf");
    check("div_ovf const", bus.result, 32'h8000_0000);
    do_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, "rem_ovf");
    check("rem_ovf const", bus.result, 32'd0);
    // start pulsed while busy must not disturb the op in flight
    do_op(F3_REMU,   32'd100,       32'd7,         5'd12, 1'b1, "remu_busy_start");
    check("remu_100/7 const", bus.result, 32'd2);

    // kill 10 cycles into an op, with an ignored start in between
    bus.funct3 = F3_MULHU; bus.rs1_val = 32'h1234_5678; bus.rs2_val = 32'h9ABC_DEF0;
    bus.rd_addr = 5'd13; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus.start = (i == 4);
      bus.funct3 = F3_DIVU; bus.rs2_val = 32'd0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.kill  = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill busy", 32'(bus.busy), 32'd0);
    check("kill done", 32'(bus.done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    check("kill no done", 32'(ndone), 32'd0);
    check("kill result held", bus.result, last_res);
    check("kill rd_out held", 32'(bus.rd_out), 32'(last_rd));

    // kill during the fast-path FIN cycle
    bus.funct3 = F3_DIVU; bus.rs1_val = 32'd77; bus.rs2_val = 32'd0;
    bus.rd_addr = 5'd14; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.kill  = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill fin done", 32'(bus.done), 32'd0);
    check("kill fin busy", 32'(bus.busy), 32'd0);
    check("kill fin result held", bus.result, last_res);

    // kill in idle beats a same-cycle start
    bus.funct3 = F3_MUL; bus.rs1_val = 32'd3; bus.rs2_val = 32'd3;
    bus.start = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    check("kill blocks start", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-calculation
    bus.funct3 = F3_MUL; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd1000;
    bus.rd_addr = 5'd15; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst busy",   32'(bus.busy),   32'd0);
    check("async rst done",   32'(bus.done),   32'd0);
    check("async rst result", bus.result,      32'd0);
    check("async rst rd_out", 32'(bus.rd_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
    last_rd  = '0;

    // back-to-back: second start lands in the first op's done cycle, rd=0
    do_op(F3_MUL,  32'd6,   32'd7,  5'd5, 1'b0, "b2b first");
    do_op(F3_DIVU, 32'd200, 32'd9,  5'd0, 1'b0, "b2b x0");
    check("b2b x0 we_out const", 32'(bus.we_out), 32'd0);

    for (int n = 0; n < 24; n++) begin
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), 1'b0, $sformatf("rand%0d", n));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
